reg_file: RTL and testbench
===========================

# reg_file

Integer register file for the core: 32 general-purpose registers of REG_LEN+1 bits, with two read ports and one write port. It sits directly upstream of the ALU operand muxes. Read port 1 drives `rs1_d`, which is operand A for the ALU1 mux. Read port 2 drives `rs2_d`, which feeds the ALU2 mux and the store path. Writeback arrives from the end of the pipeline.

## Interface
Parameters:
- REG_LEN, 31, MSB index of a data word (word width = REG_LEN+1)
- ADDR_LEN, 4, MSB index of a register address (5-bit addresses, 32 registers)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- rs1_a  in  ADDR_LEN+1  read address, port 1
- rs2_a  in  ADDR_LEN+1  read address, port 2
- rd_a  in  ADDR_LEN+1  write address
- rd_d  in  REG_LEN+1  write data
- rd_we  in  1  write enable
- hold  in  1  freeze read outputs (pipeline stall)
- rs1_d  out  REG_LEN+1  registered read data, port 1
- rs2_d  out  REG_LEN+1  registered read data, port 2

## Operation
- Storage covers x1..x31. x0 is not stored: it always reads 0, and writes to it are discarded.
- Write: on a rising edge with rd_we=1 and rd_a≠0, reg[rd_a] takes rd_d.
- Read: on a rising edge with hold=0, rs1_d takes the value of reg[rs1_a] and rs2_d takes the value of reg[rs2_a]. Address 0 yields 0.
- Hold: while hold=1, rs1_d and rs2_d keep their values. Writes still complete normally.
- Same-address read and write in one cycle: the result depends on REG_FILE_BYPASS_EN (see Configuration).
- Both read ports may name the same register, including the write target. Each port resolves independently.
- Reset: asserting rst clears all of x1..x31 and both outputs to 0 at once, with no clock needed. Any in-flight write is lost. Deasserting rst takes effect at the next rising edge.
- There is no error condition. Every address is legal.

## Timing
- Read latency is one cycle. Addresses presented before edge N appear on rs*_d after edge N.
- Write latency is one cycle. Data presented before edge N is stored at edge N and is readable by a read captured at edge N+1.
- Reset values: rs1_d = 0, rs2_d = 0, all registers = 0.
- Outputs change only on a clock edge or on rst assertion. There is no combinational path from inputs to outputs.
- hold asserted at edge N: the outputs sampled after edge N equal those sampled after edge N-1.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- With the macro defined: if rd_we=1, rd_a≠0 and rd_a equals rs1_a (or rs2_a) at the same edge, the matching output captures rd_d. This is write-first forwarding. It applies only when hold=0.
- With the macro undefined: the matching output captures the old register content (read-first). The new value is visible from the following read onward.
- In both builds, x0 reads 0 even when a write to x0 is attempted in the same cycle.

## Structure
- Shared package/header holds:
  - REG_LEN and ADDR_LEN defaults
  - register count (32)
  - the X0 index constant (5'd0)
  - a zero-word constant
- No sub-module. The register array, two read-capture registers and the optional bypass compare all live in reg_file. The bypass logic is a per-port compare and mux, implemented inline twice.

## Test plan
- Reset: drive rst=0 mid-run after writing x5=32'hDEADBEEF, then release and read x5 → rs1_d=0 and rs2_d=0 immediately on rst assertion, and x5 reads 0 afterwards.
- Write/read: write x3=32'd10 and x4=-32'd4 on consecutive edges, then read rs1_a=3, rs2_a=4 → one cycle later rs1_d=32'd10, rs2_d=32'hFFFFFFFC.
- x0: write x0=32'd7 with rd_we=1, then read rs1_a=0 → rs1_d=0.
- Same-cycle collision: x6 holds 32'd1; write x6=32'd16 while rs1_a=6 at the same edge → rs1_d=32'd16 with REG_FILE_BYPASS_EN defined, 32'd1 without. At the next edge rs1_d=32'd16 in both builds.
- Hold: with rs2_d=32'd3 from x2, assert hold for 3 cycles while writing x2=32'd4 and changing rs2_a to 9 → rs2_d stays 32'd3. After hold drops and rs2_a=2, the next edge gives rs2_d=32'd4.
- Dual port, same address: rs1_a=rs2_a=31 after writing x31=-32'd16 → both outputs read 32'hFFFFFFF0 on the same cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the integer register file: default widths,
// register count, the x0 index and an all-zero data word.
package reg_file_pkg;

  localparam int unsigned REG_LEN_DEF  = 31;
  localparam int unsigned ADDR_LEN_DEF = 4;
  localparam int unsigned NUM_REGS     = 32;

  localparam logic [4:0]  X0_IDX    = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'd0;

endpackage

// File: rtl/reg_file.sv
// Integer register file: x1..x31 storage, two registered read ports,
// one write port, and a hold input that freezes the read outputs.
// x0 is not stored and always reads zero.
// Optional build macro REG_FILE_BYPASS_EN: when defined, a write to the
// register being read at the same edge is forwarded to the read output
// (write-first); when undefined, the read captures the old content.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_LEN  = REG_LEN_DEF,
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN:0]   rs1_a,
  input  logic [ADDR_LEN:0]   rs2_a,
  input  logic [ADDR_LEN:0]   rd_a,
  input  logic [REG_LEN:0]    rd_d,
  input  logic                rd_we,
  input  logic                hold,
  output logic [REG_LEN:0]    rs1_d,
  output logic [REG_LEN:0]    rs2_d
);

  localparam logic [REG_LEN:0]  ZERO_W = (REG_LEN+1)'(ZERO_WORD);
  localparam logic [ADDR_LEN:0] X0_A   = (ADDR_LEN+1)'(X0_IDX);

  logic [REG_LEN:0] regs_q [1:NUM_REGS-1];
  logic [REG_LEN:0] regs_d [1:NUM_REGS-1];
  logic [REG_LEN:0] rs1_data_q, rs1_data_d;
  logic [REG_LEN:0] rs2_data_q, rs2_data_d;
  logic [REG_LEN:0] rd1_raw_s, rd2_raw_s;
  logic             wr_en_s;

  // Writes to x0 are dropped here so x0 never needs storage.
  assign wr_en_s = rd_we && (rd_a != X0_A);

  // Next state of the register array: only the addressed entry changes.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s) begin
      regs_d[rd_a] = rd_d;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= ZERO_W;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Raw array reads; address 0 decodes to zero instead of storage.
  always_comb begin
    rd1_raw_s = ZERO_W;
    rd2_raw_s = ZERO_W;
    if (rs1_a != X0_A) begin
      rd1_raw_s = regs_q[rs1_a];
    end else begin
      rd1_raw_s = ZERO_W;
    end
    if (rs2_a != X0_A) begin
      rd2_raw_s = regs_q[rs2_a];
    end else begin
      rd2_raw_s = ZERO_W;
    end
  end

  // Per-port capture value: hold keeps the old output, otherwise take the
  // array read, optionally overridden by a same-edge write to that address.
  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (hold) begin
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
    end else begin
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_s && (rd_a == rs1_a)) begin
        rs1_data_d = rd_d;
      end else begin
        rs1_data_d = rd1_raw_s;
      end
      if (wr_en_s && (rd_a == rs2_a)) begin
        rs2_data_d = rd_d;
      end else begin
        rs2_data_d = rd2_raw_s;
      end
`else
      rs1_data_d = rd1_raw_s;
      rs2_data_d = rd2_raw_s;
`endif
    end
  end

  // Read output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_data_q <= ZERO_W;
      rs2_data_q <= ZERO_W;
    end else begin
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign rs1_d = rs1_data_q;
  assign rs2_d = rs2_data_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by
// randomized traffic, all compared against an array-based model.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [31:0] rd_d;
  logic        rd_we, hold;
  logic [31:0] rs1_d, rs2_d;

  int vec_cnt;
  int err_cnt;

  logic [31:0] mdl_mem [32];
  logic [31:0] exp1, exp2;
  bit          bypass;

  reg_file dut (
    .clk   (clk),
    .rst   (rst),
    .rs1_a (rs1_a),
    .rs2_a (rs2_a),
    .rd_a  (rd_a),
    .rd_d  (rd_d),
    .rd_we (rd_we),
    .hold  (hold),
    .rs1_d (rs1_d),
    .rs2_d (rs2_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (bypass && we && wa == a) return wd;
    return mdl_mem[a];
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl_mem[i] = 32'd0;
    exp1 = 32'd0;
    exp2 = 32'd0;
  endtask

  // One clock: apply inputs, let the edge happen, update the model, check.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2, input logic h,
                     input string tag);
    rd_we = we; rd_a = wa; rd_d = wd; rs1_a = a1; rs2_a = a2; hold = h;
    @(posedge clk);
    if (!h) begin
      exp1 = mdl_read(a1, we, wa, wd);
      exp2 = mdl_read(a2, we, wa, wd);
    end
    if (we && wa != 5'd0) mdl_mem[wa] = wd;
    #1;
    check({tag, "_rs1"}, rs1_d, exp1);
    check({tag, "_rs2"}, rs2_d, exp2);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
`ifdef REG_FILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    mdl_clear();
    rst = 1'b0; rd_we = 1'b0; rd_a = 5'd0; rd_d = 32'd0;
    rs1_a = 5'd0; rs2_a = 5'd0; hold = 1'b0;
    #3;
    check("reset_rs1", rs1_d, 32'd0);
    check("reset_rs2", rs2_d, 32'd0);
    #4 rst = 1'b1;

    // Write then read back, including a negative value.
    cyc(1'b1, 5'd3, 32'd10, 5'd0, 5'd0, 1'b0, "wr_x3");
    cyc(1'b1, 5'd4, 32'hFFFF_FFFC, 5'd0, 5'd0, 1'b0, "wr_x4");
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, "rd_x3_x4");
    check("rd_x3_const", rs1_d, 32'd10);
    check("rd_x4_const", rs2_d, 32'hFFFF_FFFC);

    // x0 is never written, even with a same-edge read of x0.
    cyc(1'b1, 5'd0, 32'd7, 5'd0, 5'd3, 1'b0, "wr_x0_coll");
    check("x0_coll_const", rs1_d, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "rd_x0");
    check("x0_const", rs1_d, 32'd0);

    // Same-edge write/read collision on x6.
    cyc(1'b1, 5'd6, 32'd1, 5'd0, 5'd0, 1'b0, "wr_x6_init");
    cyc(1'b1, 5'd6, 32'd16, 5'd6, 5'd6, 1'b0, "coll_x6");
`ifdef REG_FILE_BYPASS_EN
    check("coll_x6_const", rs1_d, 32'd16);
`else
    check("coll_x6_const", rs1_d, 32'd1);
`endif
    cyc(1'b0, 5'd0, 32'd0, 5'd6, 5'd0, 1'b0, "after_coll_x6");
    check("after_coll_const", rs1_d, 32'd16);

    // Hold freezes outputs while a write still lands.
    cyc(1'b1, 5'd2, 32'd3, 5'd0, 5'd0, 1'b0, "wr_x2");
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd2, 1'b0, "rd_x2");
    cyc(1'b1, 5'd2, 32'd4, 5'd0, 5'd9, 1'b1, "hold1");
    check("hold1_const", rs2_d, 32'd3);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b1, "hold2");
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b1, "hold3");
    check("hold3_const", rs2_d, 32'd3);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd2, 1'b0, "unhold");
    check("unhold_const", rs2_d, 32'd4);

    // Both ports on the same register.
    cyc(1'b1, 5'd31, 32'hFFFF_FFF0, 5'd0, 5'd0, 1'b0, "wr_x31");
    cyc(1'b0, 5'd0, 32'd0, 5'd31, 5'd31, 1'b0, "dual_x31");
    check("dual_rs1_const", rs1_d, 32'hFFFF_FFF0);
    check("dual_rs2_const", rs2_d, 32'hFFFF_FFF0);

    // Asynchronous reset mid-cycle clears outputs and storage.
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, "wr_x5");
    cyc(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, "rd_x5");
    rd_we = 1'b1; rd_a = 5'd7; rd_d = 32'h1234_5678;
    #2 rst = 1'b0;
    #1;
    mdl_clear();
    check("async_rst_rs1", rs1_d, 32'd0);
    check("async_rst_rs2", rs2_d, 32'd0);
    #2 rst = 1'b1;
    cyc(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b0, "post_rst");
    check("post_rst_x5_const", rs1_d, 32'd0);

    // Randomized traffic against the model; small address range to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      logic        we, h;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      we = ($urandom_range(0, 2) != 0);
      h  = ($urandom_range(0, 4) == 0);
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a1 = wa;
      wd = $urandom;
      cyc(we, wa, wd, a1, a2, h, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
